mem_port_arbiter: RTL and testbench

- Two-master arbiter that shares the single main-memory port (burst-capable PSRAM controller path) between master 0 (CPU cache lowmem side) and master 1 (DMA-class requester, e.g. video fetch or boot loader).
- Sits between the requesters and the memory controller.
- Round-robin grant; a grant is held for a whole single or burst transaction.
- Optional watchdog aborts hung transactions.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin two-master arbiter for the shared burst memory port.
// Optional watchdog abort enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int DEFAULT_OWNER = 0,
  parameter int TIMEOUT       = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_burst_en,
  input  logic [7:0]  m0_burst_length,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  input  logic        m1_burst_en,
  input  logic [7:0]  m1_burst_length,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic        s_burst_en,
  output logic [7:0]  s_burst_length,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_we,
  output logic        s_rd,
  input  logic [31:0] s_spo,
  input  logic        s_ready,
  output logic [1:0]  grant,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_REL
  } state_t;

  state_t      r_state;
  logic        r_owner;
  logic        r_last;
  logic [8:0]  r_cnt;
  logic [31:0] r_spo0;
  logic [31:0] r_spo1;

  logic        w_req0;
  logic        w_req1;
  logic        w_pick;
  logic        w_be;
  logic [7:0]  w_len;
  logic [8:0]  w_load;
  logic        w_own;
  logic        w_oreq;
  logic        w_beat;
  logic        w_to;
  logic        w_rdy;
  logic [31:0] w_ospo;

  assign w_req0 = m0_rd | m0_we;
  assign w_req1 = m1_rd | m1_we;
  assign w_pick = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_be   = w_pick ? m1_burst_en : m0_burst_en;
  assign w_len  = w_pick ? m1_burst_length : m0_burst_length;
  assign w_load = (!w_be || w_len == 8'd0) ? 9'd1 : {1'b0, w_len};

  assign w_own  = (r_state == S_OWN);
  assign w_oreq = r_owner ? w_req1 : w_req0;
  assign w_beat = w_own & w_oreq & s_ready;

`ifdef ARB_TIMEOUT_EN
  logic [31:0] r_wd;

  assign w_to = w_own & w_oreq & ~s_ready
              & (r_wd == 32'(TIMEOUT - 1));
  assign err  = w_to;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else if (!w_own || s_ready) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 32'd1;
    end
  end
`else
  assign w_to = 1'b0;
  assign err  = 1'b0;
`endif

  assign w_rdy  = w_beat | w_to;
  assign w_ospo = w_to ? 32'hDEADBEEF : s_spo;

  // Slave side follows the owner; an abort drops the strobes at once.
  assign s_rd = w_own & ~w_to & (r_owner ? m1_rd : m0_rd);
  assign s_we = w_own & ~w_to & (r_owner ? m1_we : m0_we);
  assign s_burst_en = w_own
                    & (r_owner ? m1_burst_en : m0_burst_en);
  assign s_burst_length = !w_own ? 8'd0
                        : r_owner ? m1_burst_length
                        : m0_burst_length;
  assign s_a = !w_own ? 32'd0 : r_owner ? m1_a : m0_a;
  assign s_d = !w_own ? 32'd0 : r_owner ? m1_d : m0_d;

  assign grant = !w_own ? 2'b00 : r_owner ? 2'b10 : 2'b01;

  assign m0_ready = w_rdy & ~r_owner;
  assign m1_ready = w_rdy & r_owner;
  assign m0_spo   = (w_own & ~r_owner) ? w_ospo : r_spo0;
  assign m1_spo   = (w_own & r_owner) ? w_ospo : r_spo1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= (DEFAULT_OWNER == 0);
      r_cnt   <= '0;
      r_spo0  <= '0;
      r_spo1  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_owner <= w_pick;
            r_cnt   <= w_load;
            r_state <= S_OWN;
          end
        end
        S_OWN: begin
          if (r_owner) r_spo1 <= w_ospo;
          else         r_spo0 <= w_ospo;
          if (w_to || !w_oreq) begin
            r_last  <= r_owner;
            r_state <= S_REL;
          end else if (w_beat) begin
            r_cnt <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) begin
              r_last  <= r_owner;
              r_state <= S_REL;
            end
          end
        end
        S_REL: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level reference.
// Define ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=16).
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mrd[2], mwe[2], mbe[2];
  logic [7:0]  mbl[2];
  logic [31:0] ma[2], md[2];
  logic [31:0] m0_spo, m1_spo, s_a, s_d, s_spo;
  logic        m0_ready, m1_ready, s_burst_en, s_we, s_rd;
  logic        s_ready, err;
  logic [7:0]  s_burst_length;
  logic [1:0]  grant;

  mem_port_arbiter #(.DEFAULT_OWNER(0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_burst_en(mbe[0]), .m0_burst_length(mbl[0]),
    .m0_a(ma[0]), .m0_d(md[0]), .m0_we(mwe[0]), .m0_rd(mrd[0]),
    .m0_spo(m0_spo), .m0_ready(m0_ready),
    .m1_burst_en(mbe[1]), .m1_burst_length(mbl[1]),
    .m1_a(ma[1]), .m1_d(md[1]), .m1_we(mwe[1]), .m1_rd(mrd[1]),
    .m1_spo(m1_spo), .m1_ready(m1_ready),
    .s_burst_en(s_burst_en), .s_burst_length(s_burst_length),
    .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd),
    .s_spo(s_spo), .s_ready(s_ready),
    .grant(grant), .err(err)
  );

  int n_tests = 0;
  int n_fail = 0;

  // reference: phase 0 idle, 1 owned, 2 release
  int ph, own, last, left, wd;
  logic [31:0] mspo[2];
  logic [1:0]  p_grant;
  logic        p_rdy[2], p_to, p_srd, p_swe, p_sbe;
  logic [31:0] p_spo[2], p_sa, p_sd;
  logic [7:0]  p_sbl;

  // agents and logging
  logic hold[2], fin[2];
  int pend[2];
  int gap_pct = 100, sr_pct = 0;
  logic [1:0] glog[$];
  logic [1:0] prev_g;
  int rcnt[2], errcnt, own_run, m0_run_at_rdy;
  logic [31:0] m0_spo_at_rdy;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = 0; own = 0; last = 1; left = 0; wd = 0;
    mspo[0] = '0; mspo[1] = '0;
    p_to = 1'b0; prev_g = 2'b00; own_run = 0;
    for (int i = 0; i < 2; i++) begin
      mrd[i] = 0; mwe[i] = 0; mbe[i] = 0; mbl[i] = 0;
      ma[i] = 0; md[i] = 0;
      hold[i] = 0; fin[i] = 0; pend[i] = 0;
    end
  endtask

  task automatic predict();
    logic req;
    req = (ph == 1) && (mrd[own] || mwe[own]);
    p_to = 1'b0;
`ifdef ARB_TIMEOUT_EN
    if (req && !s_ready && wd == TO - 1) p_to = 1'b1;
`endif
    p_grant = (ph != 1) ? 2'b00 : (own == 1) ? 2'b10 : 2'b01;
    p_srd = (ph == 1) && mrd[own] && !p_to;
    p_swe = (ph == 1) && mwe[own] && !p_to;
    p_sbe = (ph == 1) && mbe[own];
    p_sbl = (ph == 1) ? mbl[own] : 8'd0;
    p_sa  = (ph == 1) ? ma[own] : 32'd0;
    p_sd  = (ph == 1) ? md[own] : 32'd0;
    for (int i = 0; i < 2; i++) begin
      p_rdy[i] = (ph == 1) && (i == own) && ((s_ready && req) || p_to);
      p_spo[i] = ((ph == 1) && (i == own))
               ? (p_to ? 32'hDEADBEEF : s_spo) : mspo[i];
    end
  endtask

  task automatic model_edge();
    bit r0, r1;
    r0 = mrd[0] || mwe[0];
    r1 = mrd[1] || mwe[1];
    if (ph == 0) begin
      if (r0 || r1) begin
        own = (r0 && r1) ? 1 - last : (r1 ? 1 : 0);
        left = (!mbe[own] || mbl[own] == 0) ? 1 : int'(mbl[own]);
        wd = 0;
        ph = 1;
      end
    end else if (ph == 1) begin
      mspo[own] = p_spo[own];
      if (p_to || !(own ? r1 : r0)) begin
        ph = 2; last = own;
      end else if (s_ready) begin
        left--;
        if (left == 0) begin ph = 2; last = own; end
      end
      wd = s_ready ? 0 : wd + 1;
    end else begin
      ph = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic look();
    #4;
    predict();
    chk("grant", 32'(grant), 32'(p_grant));
    chk("s_rd", 32'(s_rd), 32'(p_srd));
    chk("s_we", 32'(s_we), 32'(p_swe));
    chk("s_burst_en", 32'(s_burst_en), 32'(p_sbe));
    chk("s_burst_length", 32'(s_burst_length), 32'(p_sbl));
    chk("s_a", s_a, p_sa);
    chk("s_d", s_d, p_sd);
    chk("m0_ready", 32'(m0_ready), 32'(p_rdy[0]));
    chk("m1_ready", 32'(m1_ready), 32'(p_rdy[1]));
    chk("m0_spo", m0_spo, p_spo[0]);
    chk("m1_spo", m1_spo, p_spo[1]);
    chk("err", 32'(err), 32'(p_to));
    for (int i = 0; i < 2; i++)
      if (p_rdy[i] && (p_to || left == 1)) fin[i] = 1;
    if (grant != 2'b00 && prev_g == 2'b00) glog.push_back(grant);
    if (grant != 2'b00 && grant == prev_g) own_run++;
    else own_run = (grant != 2'b00) ? 1 : 0;
    prev_g = grant;
    if (m0_ready) begin
      rcnt[0]++;
      m0_run_at_rdy = own_run;
      m0_spo_at_rdy = m0_spo;
    end
    if (m1_ready) rcnt[1]++;
    if (err) errcnt++;
  endtask

  task automatic drive_agents();
    for (int i = 0; i < 2; i++) begin
      if (fin[i]) begin
        mrd[i] = 0; mwe[i] = 0; fin[i] = 0; hold[i] = 0;
      end else if (!hold[i] && pend[i] > 0
                   && $urandom_range(99) < gap_pct) begin
        mrd[i] = ($urandom_range(1) == 0);
        mwe[i] = !mrd[i];
        ma[i] = $urandom();
        md[i] = $urandom();
        mbe[i] = ($urandom_range(2) == 0);
        mbl[i] = 8'($urandom_range(9));
        hold[i] = 1;
        pend[i]--;
      end
    end
    s_ready = ($urandom_range(99) < sr_pct);
    s_spo = $urandom();
  endtask

  task automatic run_until_idle(int maxc);
    bit done;
    done = 0;
    for (int c = 0; c < maxc && !done; c++) begin
      tick();
      drive_agents();
      look();
      if (pend[0] == 0 && pend[1] == 0 && !hold[0] && !hold[1]
          && ph == 0 && c > 2) done = 1;
    end
    chk("run_done", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_rd", 32'(s_rd), 32'd0);
    chk("rst_s_we", 32'(s_we), 32'd0);
    chk("rst_s_a", s_a, 32'd0);
    chk("rst_s_burst_en", 32'(s_burst_en), 32'd0);
    chk("rst_m1_ready", 32'(m1_ready), 32'd0);
    chk("rst_m1_spo", m1_spo, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    model_reset();
    s_ready = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    s_ready = 0;
    s_spo = 0;
    errcnt = 0;
    rcnt[0] = 0; rcnt[1] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    look();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_m0_spo", m0_spo, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single read by m0
    tick(); mrd[0] = 1; ma[0] = 32'h2000_0010; look();
    chk("sr_wait_grant", 32'(grant), 32'd0);
    tick(); look();
    chk("sr_grant", 32'(grant), 32'd1);
    chk("sr_s_a", s_a, 32'h2000_0010);
    tick(); look();
    tick(); look();
    tick(); s_ready = 1; s_spo = 32'h1234_5678; look();
    chk("sr_m0_ready", 32'(m0_ready), 32'd1);
    chk("sr_m0_spo", m0_spo, 32'h1234_5678);
    tick(); s_ready = 0; s_spo = 0; mrd[0] = 0; fin[0] = 0; look();
    chk("sr_release", 32'(grant), 32'd0);
    chk("sr_spo_hold", m0_spo, 32'h1234_5678);
    tick(); look();

    // contention right after reset
    do_reset();
    tick();
    mrd[0] = 1; ma[0] = 32'h100;
    mwe[1] = 1; ma[1] = 32'h200; md[1] = 32'hA5A5_A5A5;
    look();
    tick(); look();
    chk("ct_first", 32'(grant), 32'd1);
    tick(); s_ready = 1; look();
    chk("ct_m0_ready", 32'(m0_ready), 32'd1);
    tick(); s_ready = 0; mrd[0] = 0; fin[0] = 0; look();
    chk("ct_release", 32'(grant), 32'd0);
    tick(); look();
    chk("ct_idle", 32'(grant), 32'd0);
    tick(); look();
    chk("ct_second", 32'(grant), 32'd2);
    chk("ct_s_d", s_d, 32'hA5A5_A5A5);
    tick(); s_ready = 1; look();
    chk("ct_m1_ready", 32'(m1_ready), 32'd1);
    tick(); s_ready = 0; mwe[1] = 0; fin[1] = 0; look();
    tick(); look();

    // 8-word burst by m1 with m0 waiting
    glog.delete(); rcnt[0] = 0; rcnt[1] = 0;
    tick();
    mwe[1] = 1; ma[1] = 32'h300; md[1] = 32'h55;
    mbe[1] = 1; mbl[1] = 8; hold[1] = 1;
    look();
    tick(); mrd[0] = 1; ma[0] = 32'h400; hold[0] = 1; look();
    sr_pct = 100;
    run_until_idle(100);
    chk("bu_m1_beats", 32'(rcnt[1]), 32'd8);
    chk("bu_m0_beats", 32'(rcnt[0]), 32'd1);
    chk("bu_order_n", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("bu_order0", 32'(glog[0]), 32'd2);
      chk("bu_order1", 32'(glog[1]), 32'd1);
    end

    // burst_length 0 is one word
    tick();
    mrd[0] = 1; mbe[0] = 1; mbl[0] = 0; hold[0] = 1; s_ready = 0;
    look();
    tick(); look();
    chk("bl0_grant", 32'(grant), 32'd1);
    tick(); s_ready = 1; look();
    chk("bl0_ready", 32'(m0_ready), 32'd1);
    tick(); s_ready = 0; mrd[0] = 0; hold[0] = 0; fin[0] = 0; look();
    chk("bl0_release", 32'(grant), 32'd0);
    mbe[0] = 0;

    // round-robin fairness under continuous requests
    do_reset();
    glog.delete();
    pend[0] = 3; pend[1] = 3; gap_pct = 100; sr_pct = 50;
    run_until_idle(1000);
    chk("rr_n", 32'(glog.size()), 32'd6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      chk("rr_grant", 32'(glog[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

`ifdef ARB_TIMEOUT_EN
    // watchdog: slave never answers
    do_reset();
    glog.delete(); errcnt = 0; m0_run_at_rdy = 0;
    m0_spo_at_rdy = 0;
    tick(); mrd[0] = 1; hold[0] = 1; s_ready = 0; look();
    tick(); mwe[1] = 1; hold[1] = 1; look();
    sr_pct = 0;
    run_until_idle(100);
    chk("to_run", 32'(m0_run_at_rdy), 32'd16);
    chk("to_spo", m0_spo_at_rdy, 32'hDEAD_BEEF);
    chk("to_err", 32'(errcnt), 32'd2);
    chk("to_n", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) chk("to_next", 32'(glog[1]), 32'd2);
`endif

    // reset in the middle of a burst
    tick();
    mwe[1] = 1; mbe[1] = 1; mbl[1] = 8; hold[1] = 1; s_ready = 0;
    look();
    tick(); look();
    tick(); s_ready = 1; look();
    tick(); s_ready = 0; look();
    chk("mr_grant", 32'(grant), 32'd2);
    do_reset();
    tick(); look();

    // long random run
    pend[0] = 40; pend[1] = 40; gap_pct = 30; sr_pct = 40;
    run_until_idle(20000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
